// File: rtl/subtraction_new_if.sv
// subtraction_new_if: start/operand/result bundle shared by the wide subtractor and its driver.
interface subtraction_new_if #(parameter int Size_sub = 3328);
    logic                en;
    logic [Size_sub-1:0] a;
    logic [Size_sub-1:0] b;
    logic [Size_sub-1:0] c;
    logic                borrow_out;
    logic                busy;
    logic                en_out;
    modport master (output en, a, b, input c, borrow_out, busy, en_out);
    modport slave (input en, a, b, output c, borrow_out, busy, en_out);
endinterface

// File: rtl/subtraction_new.sv
// subtraction_new: multi-precision a-b with borrow-select over 256-bit limbs, one op per 4 cycles.
module subtraction_new #(
    parameter int Size_sub = 3328,
    parameter int LIMB_W   = 256,
    parameter int N_LIMB   = 13
) (
    input logic clk,
    input logic rst,
    subtraction_new_if.slave s
);
    typedef enum logic [1:0] {IDLE, D0, D1, SEL} state_t;
    state_t              state, state_nx;
    logic [Size_sub-1:0] a_q, b_q, res;
    logic [LIMB_W:0]     d0 [N_LIMB];
    logic [LIMB_W:0]     d1 [N_LIMB];
    logic [LIMB_W:0]     sel;
    logic                brw;
    assign s.busy = state != IDLE;
    always_comb begin
        state_nx = (state == IDLE) ? (s.en ? D0 : IDLE) :
                   (state == D0)   ? D1 :
                   (state == D1)   ? SEL : IDLE;
    end
    // d0 assumes no borrow into a limb, d1 assumes one; the incoming borrow picks between them.
    always_comb begin
        res = '0;
        sel = '0;
        res[LIMB_W-1:0] = d0[0][LIMB_W-1:0];
        brw = d0[0][LIMB_W];
        for (int p = 1; p < N_LIMB; p++) begin
            sel = brw ? d1[p] : d0[p];
            res[p*LIMB_W +: LIMB_W] = sel[LIMB_W-1:0];
            brw = sel[LIMB_W];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            s.c          <= '0;
            s.borrow_out <= 1'b0;
            s.en_out     <= 1'b0;
            for (int p = 0; p < N_LIMB; p++) begin
                d0[p] <= '0;
                d1[p] <= '0;
            end
        end else begin
            state    <= state_nx;
            s.en_out <= state == SEL;
            if (state == IDLE && s.en) begin
                a_q <= s.a;
                b_q <= s.b;
            end
            for (int p = 0; p < N_LIMB; p++) begin
                if (state == D0)
                    d0[p] <= {1'b0, a_q[p*LIMB_W +: LIMB_W]} - {1'b0, b_q[p*LIMB_W +: LIMB_W]};
                if (state == D1)
                    d1[p] <= {1'b0, a_q[p*LIMB_W +: LIMB_W]} - {1'b0, b_q[p*LIMB_W +: LIMB_W]}
                             - {{LIMB_W{1'b0}}, 1'b1};
            end
            if (state == SEL) begin
                s.c          <= res;
                s.borrow_out <= brw;
            end
        end
    end
endmodule
